// File: rtl/dma_arb_pkg.sv
// dma_arb_pkg: shared state encoding and limits for the DMA channel arbiter
package dma_arb_pkg;
    localparam int NUM_CH_MAX = 8;
    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_REQ     = 4'b0010,
        S_GRANT   = 4'b0100,
        S_RELEASE = 4'b1000
    } state_e;
endpackage

// File: rtl/dma_prio_encoder.sv
// dma_prio_encoder: rotate eligible requests by the pointer, then pick the first set channel
module dma_prio_encoder #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              valid_o
);
    // scan from lowest to highest priority so the highest-priority hit is written last
    always_comb begin
        int c;
        c = 0;
        idx_o = '0;
        valid_o = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            c = i + int'(ptr_i);
            c = (c >= NUM_CH) ? c - NUM_CH : c;
            if (eligible_i[c[IDX_W-1:0]]) begin
                idx_o = c[IDX_W-1:0];
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter: hold-request / channel-grant arbiter; define DMA_ARB_MASK_EN to let chMask gate eligibility
module dma_channel_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic              EOP_N,
    input  logic              priorityType,
    input  logic              serviceDone,
    input  logic [NUM_CH-1:0] chMask,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic [IDX_W-1:0]  activeCh,
    output logic              grantValid
);
    state_e              state_q, state_d;
    logic                hrq_q, hrq_d;
    logic [NUM_CH-1:0]   dack_q, dack_d, dack_one, eff_mask, eligible;
    logic [IDX_W-1:0]    act_q, act_d, ptr_q, ptr_d, ptr_next, enc_ptr, win_idx;
    logic                win_valid, done, grant_edge;

`ifdef DMA_ARB_MASK_EN
    assign eff_mask = chMask;
`else
    logic unused_mask;
    assign unused_mask = ^chMask;
    assign eff_mask = '0;
`endif

    assign eligible = DREQ & ~eff_mask;
    assign done     = serviceDone | ~EOP_N;
    assign enc_ptr  = priorityType ? ptr_q : '0;
    assign dack_one = {{(NUM_CH-1){1'b0}}, 1'b1} << win_idx;
    assign ptr_next = (act_q == IDX_W'(NUM_CH - 1)) ? '0 : act_q + IDX_W'(1);

    dma_prio_encoder #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_enc (
        .eligible_i (eligible),
        .ptr_i      (enc_ptr),
        .idx_o      (win_idx),
        .valid_o    (win_valid)
    );

    // state and registered outputs; reset clears everything so DACK/HRQ drop at once
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            hrq_q   <= 1'b0;
            dack_q  <= '0;
            act_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            hrq_q   <= hrq_d;
            dack_q  <= dack_d;
            act_q   <= act_d;
            ptr_q   <= ptr_d;
        end
    end

    // next state: abort (HLDA low) in GRANT takes precedence over completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = (|eligible) ? S_REQ : S_IDLE;
            S_REQ:     state_d = !HLDA ? S_REQ : win_valid ? S_GRANT : S_RELEASE;
            S_GRANT:   state_d = !HLDA ? S_IDLE : done ? S_RELEASE : S_GRANT;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // next output values: winner latched only on REQ->GRANT, pointer advanced only on completion
    always_comb begin
        grant_edge = (state_q == S_REQ) && (state_d == S_GRANT);
        hrq_d      = (state_d == S_REQ) || (state_d == S_GRANT);
        dack_d     = (state_d != S_GRANT) ? '0 : grant_edge ? dack_one : dack_q;
        act_d      = grant_edge ? win_idx : act_q;
        ptr_d      = ((state_q == S_GRANT) && (state_d == S_RELEASE)) ? ptr_next : ptr_q;
    end

    assign HRQ        = hrq_q;
    assign DACK       = dack_q;
    assign activeCh   = act_q;
    assign grantValid = |dack_q;
endmodule
